mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports ireq (input, 1) and iaddr (input, 32): instruction-fetch read request and its address.
REQ-004 SHALL have ports irdata (output, 32) and StallF (output, 1): fetch read data and fetch-stage stall.
REQ-005 SHALL have ports dreq, dwe (input, 1 each), daddr and dwdata (input, 32 each): data-memory request, write enable, address and write data.
REQ-006 SHALL have ports drdata (output, 32) and StallM (output, 1): data read data and memory-stage stall.
REQ-007 SHALL have ports mem_req, mem_we (output, 1 each), mem_addr and mem_wdata (output, 32 each): shared single-port memory command.
REQ-008 SHALL have ports mem_rdata (input, 32) and mem_ready (input, 1): memory response; an access completes in the cycle where mem_req and mem_ready are both high.

Function
REQ-009 SHALL keep a registered state: ARB_IDLE, ARB_IFETCH or ARB_DATA.
REQ-010 In ARB_IDLE, SHALL drive mem_req=0 and pick the next grantee from pending ireq/dreq per REQ-016; with no request pending, SHALL stay in ARB_IDLE.
REQ-011 In ARB_IFETCH, SHALL drive mem_req=1, mem_we=0, mem_addr=iaddr and mem_wdata=0.
REQ-012 In ARB_DATA, SHALL drive mem_req=1, mem_we=dwe, mem_addr=daddr and mem_wdata=dwdata.
REQ-013 While a grant is active and mem_ready=0, SHALL hold state; mem_* outputs follow the grantee's inputs, which the stalled pipeline keeps stable.
REQ-014 On completion, SHALL move next cycle directly to the grant chosen by REQ-016 among requests pending in that cycle, else to ARB_IDLE; there is no idle bubble between back-to-back accesses.
REQ-015 SHALL compute StallF = ireq && !(state==ARB_IFETCH && mem_ready) and StallM = dreq && !(state==ARB_DATA && mem_ready), combinationally.
REQ-016 Selection without the macro: dreq wins over ireq when both are pending (the older instruction proceeds).
REQ-017 SHALL pass irdata = mem_rdata and drdata = mem_rdata; each is valid only in its grantee's completion cycle.
REQ-018 A request deasserted while granted and before completion (pipeline flush) SHALL return state to ARB_IDLE next cycle without completing; the memory sees the dropped access as cancelled.
REQ-019 A data write completes like a read; drdata is don't-care in that cycle.
REQ-020 Minimum latency SHALL be 2 cycles from a request arriving in ARB_IDLE (one arbitration cycle, then memory with mem_ready=1).

Reset
REQ-021 While reset is high, state SHALL be ARB_IDLE and mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-022 Reset asserted mid-access SHALL abandon the access immediately, with no completion reported.
REQ-023 Outputs SHALL depend only on state and inputs after reset release; the round-robin pointer resets to "data served last".

Configuration
REQ-024 Macro MEM_ARB_ROUNDROBIN_EN defined: on simultaneous pending requests, the requester not served most recently wins, using a 1-bit last-served register updated at each completion.
REQ-025 Macro MEM_ARB_ROUNDROBIN_EN undefined: fixed data-over-fetch priority per REQ-016 and no last-served register.

Structure
REQ-026 Package mem_arb_pkg SHALL hold typedef enum arb_state_t {ARB_IDLE, ARB_IFETCH, ARB_DATA} and localparam MEM_AW=32, MEM_DW=32.
REQ-027 SHALL be a single module with no sub-module; the priority pick is inline combinational logic.

Verification
REQ-028 ireq only, iaddr=0x40, memory ready after 1 cycle, mem_rdata=0x8C010004 -> StallF high for 1 cycle, then irdata=0x8C010004 with StallF=0.
REQ-029 ireq and dreq both high from idle, no macro, 0-wait memory -> data served first (StallM low in cycle 2), fetch in cycle 3 with no idle bubble.
REQ-030 Same stimulus as REQ-029 with MEM_ARB_ROUNDROBIN_EN and the last completion being data -> fetch served first, then data.
REQ-031 dreq, dwe=1, daddr=0x100, dwdata=0xDEADBEEF, memory 3 wait cycles -> mem_we/mem_addr/mem_wdata stable for 4 cycles, StallM high for 4 cycles.
REQ-032 Assert reset while in ARB_DATA with mem_ready=0 -> mem_req=0 in the same cycle, state ARB_IDLE, no drdata completion.
REQ-033 ireq dropped while in ARB_IFETCH before mem_ready -> ARB_IDLE next cycle, StallF=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the memory port arbiter
package mem_arb_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFETCH = 2'd1,
    ARB_DATA   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared single-port memory
// Optional MEM_ARB_ROUNDROBIN_EN: alternate winner on contention instead of data-first.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [MEM_AW-1:0] iaddr,
  output logic [MEM_DW-1:0] irdata,
  output logic              StallF,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [MEM_AW-1:0] daddr,
  input  logic [MEM_DW-1:0] dwdata,
  output logic [MEM_DW-1:0] drdata,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic [MEM_DW-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t state_q, state_d;
  arb_state_t pick;
  logic       prefer_data;

`ifdef MEM_ARB_ROUNDROBIN_EN
  logic last_data_q, last_data_d;

  always_comb begin
    last_data_d = last_data_q;
    if (mem_req && mem_ready) begin
      last_data_d = (state_q == ARB_DATA);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end

  assign prefer_data = !last_data_q;
`else
  assign prefer_data = 1'b1;
`endif

  always_comb begin
    pick = ARB_IDLE;
    if (dreq && (!ireq || prefer_data)) begin
      pick = ARB_DATA;
    end else if (ireq) begin
      pick = ARB_IFETCH;
    end
  end

  // On completion the served requester is satisfied, so only the other side can follow back-to-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: state_d = pick;
      ARB_IFETCH: begin
        if (!ireq) begin
          state_d = ARB_IDLE;
        end else if (mem_ready) begin
          state_d = dreq ? ARB_DATA : ARB_IDLE;
        end
      end
      ARB_DATA: begin
        if (!dreq) begin
          state_d = ARB_IDLE;
        end else if (mem_ready) begin
          state_d = ireq ? ARB_IFETCH : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // mem_req is gated by the grantee's request so a flushed access never completes or writes.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ARB_IFETCH: begin
        mem_req  = ireq;
        mem_addr = iaddr;
      end
      ARB_DATA: begin
        mem_req   = dreq;
        mem_we    = dwe;
        mem_addr  = daddr;
        mem_wdata = dwdata;
      end
      default: ;
    endcase
  end

  assign StallF = ireq && !((state_q == ARB_IFETCH) && mem_ready);
  assign StallM = dreq && !((state_q == ARB_DATA) && mem_ready);
  assign irdata = mem_rdata;
  assign drdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        StallF;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int passed = 0;
  int total  = 0;

  logic [31:0] first_addr, second_addr;
  logic        first_stallf, first_stallm;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .ireq      (ireq),
    .iaddr     (iaddr),
    .irdata    (irdata),
    .StallF    (StallF),
    .dreq      (dreq),
    .dwe       (dwe),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .drdata    (drdata),
    .StallM    (StallM),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 32'(dut.state_q), 32'(ARB_IDLE));
  endtask

  initial begin
    reset = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
    daddr = '0; dwdata = '0; mem_rdata = '0; mem_ready = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk_idle("rst_state");
    cyc();
    reset = 1'b0;

    // single fetch, one-cycle memory
    ireq = 1'b1; iaddr = 32'h40;
    @(negedge clk);
    chk("if_arb_stallf", 32'(StallF), 32'h1);
    chk("if_arb_mem_req", 32'(mem_req), 32'h0);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h8C01_0004;
    @(negedge clk);
    chk("if_mem_req", 32'(mem_req), 32'h1);
    chk("if_mem_we", 32'(mem_we), 32'h0);
    chk("if_mem_addr", mem_addr, 32'h40);
    chk("if_mem_wdata", mem_wdata, 32'h0);
    chk("if_stallf", 32'(StallF), 32'h0);
    chk("if_irdata", irdata, 32'h8C01_0004);
    cyc();
    ireq = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk_idle("if_done_state");

    // data write with three wait cycles
    cyc();
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_arb_stallm", 32'(StallM), 32'h1);
    chk("wr_arb_mem_req", 32'(mem_req), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      mem_ready = (i == 3);
      @(negedge clk);
      chk($sformatf("wr_mem_req_%0d", i), 32'(mem_req), 32'h1);
      chk($sformatf("wr_mem_we_%0d", i), 32'(mem_we), 32'h1);
      chk($sformatf("wr_mem_addr_%0d", i), mem_addr, 32'h100);
      chk($sformatf("wr_mem_wdata_%0d", i), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("wr_stallm_%0d", i), 32'(StallM), (i == 3) ? 32'h0 : 32'h1);
    end
    cyc();
    dreq = 1'b0; dwe = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk_idle("wr_done_state");

    // simultaneous requests, zero-wait memory; last completion was data
    first_addr   = RR ? 32'h44 : 32'h200;
    second_addr  = RR ? 32'h200 : 32'h44;
    first_stallf = RR ? 1'b0 : 1'b1;
    first_stallm = RR ? 1'b1 : 1'b0;
    cyc();
    ireq = 1'b1; dreq = 1'b1; iaddr = 32'h44; daddr = 32'h200;
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("both_c1_mem_req", 32'(mem_req), 32'h0);
    chk("both_c1_stallf", 32'(StallF), 32'h1);
    chk("both_c1_stallm", 32'(StallM), 32'h1);
    cyc();
    @(negedge clk);
    chk("both_c2_mem_req", 32'(mem_req), 32'h1);
    chk("both_c2_mem_addr", mem_addr, first_addr);
    chk("both_c2_stallf", 32'(StallF), 32'(first_stallf));
    chk("both_c2_stallm", 32'(StallM), 32'(first_stallm));
    cyc();
    if (RR) ireq = 1'b0;
    else    dreq = 1'b0;
    @(negedge clk);
    chk("both_c3_mem_req", 32'(mem_req), 32'h1);
    chk("both_c3_mem_addr", mem_addr, second_addr);
    chk("both_c3_stallf", 32'(StallF), 32'h0);
    chk("both_c3_stallm", 32'(StallM), 32'h0);
    cyc();
    ireq = 1'b0; dreq = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk_idle("both_done_state");

    // fetch flushed before the memory answers
    cyc();
    ireq = 1'b1; iaddr = 32'h80;
    @(negedge clk);
    chk("fl_arb_mem_req", 32'(mem_req), 32'h0);
    cyc();
    @(negedge clk);
    chk("fl_wait_mem_req", 32'(mem_req), 32'h1);
    chk("fl_wait_mem_addr", mem_addr, 32'h80);
    chk("fl_wait_stallf", 32'(StallF), 32'h1);
    cyc();
    ireq = 1'b0;
    @(negedge clk);
    chk("fl_drop_stallf", 32'(StallF), 32'h0);
    chk("fl_drop_mem_req", 32'(mem_req), 32'h0);
    cyc();
    @(negedge clk);
    chk_idle("fl_state");
    chk("fl_stallf", 32'(StallF), 32'h0);

    // reset asserted mid data access
    cyc();
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h300;
    @(negedge clk);
    chk("rs_arb_mem_req", 32'(mem_req), 32'h0);
    cyc();
    @(negedge clk);
    chk("rs_wait_mem_req", 32'(mem_req), 32'h1);
    chk("rs_wait_stallm", 32'(StallM), 32'h1);
    #1;
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h3333_3333;
    #1;
    chk("rs_async_mem_req", 32'(mem_req), 32'h0);
    chk("rs_async_mem_addr", mem_addr, 32'h0);
    chk_idle("rs_async_state");
    chk("rs_async_stallm", 32'(StallM), 32'h1);
    cyc();
    @(negedge clk);
    chk_idle("rs_hold_state");
    chk("rs_hold_stallm", 32'(StallM), 32'h1);
    cyc();
    reset = 1'b0; dreq = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk_idle("rs_release_state");
    chk("rs_release_mem_req", 32'(mem_req), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
